// File: rtl/interrupt_source_latch_pkg.sv
// Shared register selects and widths for the interrupt source conditioning stage.
package interrupt_source_latch_pkg;

    // Number of external sources on this CPU; sources are numbered 1..NSRC_DEF.
    localparam int NSRC_DEF = 7;
    // Width of the read data bus.
    localparam int DOUT_W = 16;

    // Register selects, alongside INT_MASK / INT_INTS / INT_PRI in the mask block.
    typedef enum logic [1:0] {
        INT_SRC_PEND = 2'b00,
        INT_SRC_MODE = 2'b01,
        INT_SRC_POL  = 2'b10,
        INT_SRC_RAW  = 2'b11
    } int_src_reg_e;

endpackage

// File: rtl/interrupt_source_latch_sync_edge.sv
// One interrupt source: 2-flop synchroniser, polarity, edge/level pending flag.
module int_sync_edge (
    input  logic CLK,
    input  logic RESET,
    input  logic PIN,
    input  logic POL,      // current polarity (1 = active-low)
    input  logic MODE,     // current mode (1 = edge latched)
    input  logic POL_WR,   // polarity bit flips on this edge
    input  logic MODE_WR,  // mode bit flips on this edge
    input  logic CLR,      // W1C or matching ACK
    output logic RAW,
    output logic PEND
);

    logic meta_q, sync_q, prev_q, pend_q;
    logic act, rise, prev_d, pend_d;

    // Next-state: a set beats a clear, and mode/polarity changes never create an edge.
    always_comb begin
        act    = sync_q ^ POL;
        rise   = act & ~prev_q & ~POL_WR & ~MODE_WR;
        // On a polarity flip, preload prev with the new active level so no edge appears.
        prev_d = POL_WR ? (sync_q ^ ~POL) : act;
        pend_d = pend_q;
        if (MODE_WR)
            pend_d = 1'b0;
        else if (!MODE)
            pend_d = act;
        else if (rise)
            pend_d = 1'b1;
        else if (CLR)
            pend_d = 1'b0;
    end

    // Synchroniser, previous-level and pending flops.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            meta_q <= PIN;
            sync_q <= meta_q;
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    assign RAW  = sync_q;
    assign PEND = pend_q;

endmodule

// File: rtl/interrupt_source_latch.sv
// Interrupt source front end: MODE/POL registers, W1C/ACK decode, read mux,
// and one int_sync_edge per source feeding INTS1..INTS7.
module interrupt_source_latch
    import interrupt_source_latch_pkg::*;
#(
    parameter int NSRC = NSRC_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NSRC:1]     IRQ,
    input  logic [1:0]        ADDR,
    input  logic [7:0]        DIN,
    input  logic              WR,
    input  logic              RD,
    output logic [DOUT_W-1:0] DOUT,
    input  logic              ACK,
    input  logic [2:0]        ACK_LEVEL,
    output logic              INTS1,
    output logic              INTS2,
    output logic              INTS3,
    output logic              INTS4,
    output logic              INTS5,
    output logic              INTS6,
    output logic              INTS7
);

    logic [NSRC:1] mode_q, mode_d, pol_q, pol_d;
    logic [NSRC:1] mode_chg, pol_chg, w1c, ack_hit;
    logic [NSRC:1] raw, pend;
    logic          unused_din;

    assign unused_din = DIN[0];

    // Write decode and per-source acknowledge match; ACK_LEVEL 0 matches nothing.
    always_comb begin
        mode_d  = mode_q;
        pol_d   = pol_q;
        w1c     = '0;
        ack_hit = '0;
        if (WR) begin
            case (int_src_reg_e'(ADDR))
                INT_SRC_PEND: w1c    = DIN[NSRC:1];
                INT_SRC_MODE: mode_d = DIN[NSRC:1];
                INT_SRC_POL:  pol_d  = DIN[NSRC:1];
                default:      ;
            endcase
        end
        for (int n = 1; n <= NSRC; n++)
            ack_hit[n] = ACK && (int'(ACK_LEVEL) == n);
        mode_chg = mode_d ^ mode_q;
        pol_chg  = pol_d ^ pol_q;
    end

    // MODE and POL configuration registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mode_q <= '0;
            pol_q  <= '0;
        end else begin
            mode_q <= mode_d;
            pol_q  <= pol_d;
        end
    end

    for (genvar n = 1; n <= NSRC; n++) begin : g_src
        int_sync_edge u_src (
            .CLK     (CLK),
            .RESET   (RESET),
            .PIN     (IRQ[n]),
            .POL     (pol_q[n]),
            .MODE    (mode_q[n]),
            .POL_WR  (pol_chg[n]),
            .MODE_WR (mode_chg[n]),
            .CLR     (w1c[n] | ack_hit[n]),
            .RAW     (raw[n]),
            .PEND    (pend[n])
        );
    end

    // Combinational read mux; bit 0 and the upper byte always read 0.
    always_comb begin
        DOUT = '0;
        if (RD) begin
            case (int_src_reg_e'(ADDR))
                INT_SRC_PEND: DOUT[NSRC:1] = pend;
                INT_SRC_MODE: DOUT[NSRC:1] = mode_q;
                INT_SRC_POL:  DOUT[NSRC:1] = pol_q;
                INT_SRC_RAW:  DOUT[NSRC:1] = raw;
                default:      DOUT = '0;
            endcase
        end
    end

    assign INTS1 = pend[1];
    assign INTS2 = pend[2];
    assign INTS3 = pend[3];
    assign INTS4 = pend[4];
    assign INTS5 = pend[5];
    assign INTS6 = pend[6];
    assign INTS7 = pend[7];

endmodule

// File: tb/tb_interrupt_source_latch.sv
// Bench for interrupt_source_latch: directed vector table, then random traffic
// against a cycle-level reference model, then a mid-operation reset.
module tb_interrupt_source_latch;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:1]  irq;
    logic [1:0]  addr;
    logic [7:0]  din;
    logic        wr, rd, ack;
    logic [2:0]  lvl;
    logic [15:0] dout;
    logic        i1, i2, i3, i4, i5, i6, i7;
    logic [7:0]  ints;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    interrupt_source_latch #(.NSRC(7)) dut (
        .CLK(clk), .RESET(rst), .IRQ(irq), .ADDR(addr), .DIN(din), .WR(wr), .RD(rd),
        .DOUT(dout), .ACK(ack), .ACK_LEVEL(lvl),
        .INTS1(i1), .INTS2(i2), .INTS3(i3), .INTS4(i4), .INTS5(i5), .INTS6(i6), .INTS7(i7)
    );

    assign ints = {i7, i6, i5, i4, i3, i2, i1, 1'b0};

    // ---------------- reference model ----------------
    // pin_dly[0] is the synchronised pin, pin_dly[1] the sample one edge younger.
    bit [7:1] pin_dly [2];
    bit [7:1] m_prev, m_pend, m_mode, m_pol;

    task automatic model_reset();
        pin_dly[0] = '0; pin_dly[1] = '0;
        m_prev = '0; m_pend = '0; m_mode = '0; m_pol = '0;
    endtask

    task automatic model_step();
        bit [7:1] raw, act, nmode, npol, w1c;
        bit clr;
        raw = pin_dly[0];
        act = raw ^ m_pol;
        nmode = m_mode; npol = m_pol; w1c = '0;
        if (wr) begin
            if (addr == 2'd0) w1c = din[7:1];
            if (addr == 2'd1) nmode = din[7:1];
            if (addr == 2'd2) npol = din[7:1];
        end
        for (int n = 1; n <= 7; n++) begin
            clr = w1c[n] || (ack && int'(lvl) == n);
            if (nmode[n] != m_mode[n]) begin
                m_pend[n] = 1'b0;
                m_prev[n] = act[n];
            end else if (npol[n] != m_pol[n]) begin
                if (!m_mode[n]) m_pend[n] = act[n];
                else if (clr)   m_pend[n] = 1'b0;
                m_prev[n] = raw[n] ^ npol[n];
            end else begin
                if (!m_mode[n])                  m_pend[n] = act[n];
                else if (act[n] && !m_prev[n])   m_pend[n] = 1'b1;
                else if (clr)                    m_pend[n] = 1'b0;
                m_prev[n] = act[n];
            end
        end
        pin_dly[0] = pin_dly[1];
        pin_dly[1] = irq;
        m_mode = nmode;
        m_pol  = npol;
    endtask

    function automatic logic [15:0] model_dout();
        bit [7:1] v;
        if (!rd) return 16'h0;
        case (addr)
            2'd0:    v = m_pend;
            2'd1:    v = m_mode;
            2'd2:    v = m_pol;
            default: v = pin_dly[0];
        endcase
        return {8'h00, v, 1'b0};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0]  irq;
        logic        wr;
        logic [1:0]  addr;
        logic [7:0]  din;
        logic        ack;
        logic [2:0]  lvl;
        logic        rd;
        logic [7:0]  ints;
        logic [15:0] dout;
    } vec_t;

    vec_t tv [64];
    int   ntv = 0;

    task automatic add(input logic [7:0] i, input logic w, input logic [1:0] a, input logic [7:0] d,
                       input logic k, input logic [2:0] l, input logic r,
                       input logic [7:0] ei, input logic [15:0] ed);
        tv[ntv] = '{i, w, a, d, k, l, r, ei, ed};
        ntv++;
    endtask

    task automatic apply(input logic [7:0] i, input logic w, input logic [1:0] a, input logic [7:0] d,
                         input logic k, input logic [2:0] l, input logic r);
        irq = i[7:1]; wr = w; addr = a; din = d; ack = k; lvl = l; rd = r;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic rand_cycles(input int n);
        logic [7:0] ri;
        ri = {irq, 1'b0};
        for (int c = 0; c < n; c++) begin
            if ($urandom_range(0, 3) == 0) ri = 8'($urandom);
            apply(ri, $urandom_range(0, 5) == 0, 2'($urandom), 8'($urandom),
                  $urandom_range(0, 3) == 0, 3'($urandom), 1'($urandom));
            check("rand_ints", {8'h0, ints}, {8'h0, m_pend, 1'b0});
            check("rand_dout", dout, model_dout());
        end
    endtask

    initial begin
        rst = 1'b1; irq = '0; addr = '0; din = '0; wr = 0; rd = 0; ack = 0; lvl = '0;
        model_reset();

        // 1: level pass-through on source 3
        add(8'h08,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'h08,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'h08,0,0,8'h00,0,0,1, 8'h08,16'h0008);
        add(8'h00,0,3,8'h00,0,0,1, 8'h08,16'h0008);
        add(8'h00,0,3,8'h00,0,0,1, 8'h08,16'h0000);
        add(8'h00,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        // 2: edge latch on source 2, then W1C
        add(8'h00,1,1,8'h04,0,0,1, 8'h00,16'h0004);
        add(8'h04,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'h04,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'h00,0,0,8'h00,0,0,0, 8'h04,16'h0000);
        add(8'h00,0,0,8'h00,0,0,0, 8'h04,16'h0000);
        add(8'h00,0,0,8'h00,0,0,1, 8'h04,16'h0004);
        add(8'h00,1,0,8'h04,0,0,1, 8'h00,16'h0000);
        // 3: acknowledge on sources 5 and 7
        add(8'h00,1,1,8'hA4,0,0,1, 8'h00,16'h00A4);
        add(8'hA0,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'hA0,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'hA0,0,0,8'h00,0,0,1, 8'hA0,16'h00A0);
        add(8'hA0,0,0,8'h00,1,7,1, 8'h20,16'h0020);
        add(8'hA0,0,0,8'h00,1,0,1, 8'h20,16'h0020);
        add(8'h00,0,0,8'h00,1,5,1, 8'h00,16'h0000);
        add(8'h00,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'h00,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        // 4: set beats W1C on source 1
        add(8'h00,1,1,8'hA6,0,0,1, 8'h00,16'h00A6);
        add(8'h02,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'h02,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'h02,1,0,8'h02,0,0,1, 8'h02,16'h0002);
        add(8'h00,1,0,8'h02,0,0,1, 8'h00,16'h0000);
        add(8'h00,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'h00,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        // 6: mode switch of a pending source 4 back to level
        add(8'h00,1,1,8'hB6,0,0,1, 8'h00,16'h00B6);
        add(8'h10,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'h10,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'h00,0,0,8'h00,0,0,0, 8'h10,16'h0000);
        add(8'h00,0,0,8'h00,0,0,0, 8'h10,16'h0000);
        add(8'h00,1,1,8'h00,0,0,1, 8'h00,16'h0000);
        add(8'h00,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'h00,0,0,8'h00,0,0,1, 8'h00,16'h0000);
        // 5: polarity flip in level mode, then in edge mode (no edge manufactured)
        add(8'h00,1,2,8'hFE,0,0,1, 8'h00,16'h00FE);
        add(8'h00,0,0,8'h00,0,0,1, 8'hFE,16'h00FE);
        add(8'h00,0,3,8'h00,0,0,1, 8'hFE,16'h0000);
        add(8'h00,1,2,8'h00,0,0,1, 8'hFE,16'h0000);
        add(8'h00,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'h00,1,1,8'hFE,0,0,1, 8'h00,16'h00FE);
        add(8'h00,1,2,8'hFE,0,0,1, 8'h00,16'h00FE);
        add(8'h00,0,0,8'h00,0,0,1, 8'h00,16'h0000);
        add(8'h00,1,2,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'h00,0,0,8'h00,0,0,0, 8'h00,16'h0000);
        add(8'h00,1,1,8'h00,0,0,0, 8'h00,16'h0000);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ints", {8'h0, ints}, 16'h0000);
        check("reset_dout_rd0", dout, 16'h0000);
        rd = 1; addr = 2'd1; #1;
        check("reset_mode", dout, 16'h0000);
        addr = 2'd2; #1;
        check("reset_pol", dout, 16'h0000);
        rd = 0; addr = 2'd0;
        rst = 1'b0;

        for (int v = 0; v < ntv; v++) begin
            apply(tv[v].irq, tv[v].wr, tv[v].addr, tv[v].din, tv[v].ack, tv[v].lvl, tv[v].rd);
            check($sformatf("vec%0d_ints", v), {8'h0, ints}, {8'h0, tv[v].ints});
            check($sformatf("vec%0d_dout", v), dout, tv[v].dout);
        end

        rand_cycles(500);

        // reset mid-operation: outputs drop immediately, nothing replayed after release
        rd = 0;
        rst = 1'b1;
        #1;
        check("midrst_ints", {8'h0, ints}, 16'h0000);
        check("midrst_dout", dout, 16'h0000);
        model_reset();
        @(posedge clk); #1;
        irq = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        apply(8'h00, 0, 0, 8'h00, 0, 0, 0);
        check("postrst_ints", {8'h0, ints}, 16'h0000);
        rand_cycles(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
